// File: rtl/dp_pkg.sv
// Shared state encoding and Q8.8 fixed-point helpers for the data-point error engine.
package dp_pkg;
    localparam int FEAT_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;
    localparam int ROW_MAX_W = 256;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

    typedef enum logic [2:0] {
        S_IDLE, S_W_ADDR, S_W_CAP, S_P_ADDR, S_P_CAP, S_MAC, S_OUT, S_DONE
    } state_e;

    // Rows are zero-extended to ROW_MAX_W by the caller so one helper serves any feature count.
    function automatic logic [FEAT_W-1:0] slice(input logic [ROW_MAX_W-1:0] row, input int k);
        return FEAT_W'(row >> (k * FEAT_W));
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic [FEAT_W-1:0] v);
        return $signed({{(ACC_W-FEAT_W){v[FEAT_W-1]}}, v});
    endfunction

    function automatic logic [FEAT_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return 16'h7FFF;
        if (v < SAT_MIN) return 16'h8000;
        return v[FEAT_W-1:0];
    endfunction
endpackage

// File: rtl/fx_mac.sv
// Signed 16x16 multiply into a 40-bit accumulator. The next accumulator value is exported so the
// final sum can be consumed on the same edge that registers it.
module fx_mac
    import dp_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [FEAT_W-1:0]       a_i,
    input  logic [FEAT_W-1:0]       b_i,
    output logic signed [ACC_W-1:0] acc_nxt_o
);
    logic signed [2*FEAT_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign prod = $signed(a_i) * $signed(b_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + $signed({{(ACC_W-2*FEAT_W){prod[2*FEAT_W-1]}}, prod});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_nxt_o = acc_d;
endmodule

// File: rtl/dp_error_engine.sv
// Epoch sequencer: loads the weight row from RAM address 0, then streams one saturated Q8.8
// prediction error per data point over a valid/ready interface.
//   state    | meaning
//   IDLE     | waiting for start
//   W_ADDR   | present address 0, enable RAM
//   W_CAP    | capture weights and bias
//   P_ADDR   | present data-point address
//   P_CAP    | capture data row, clear accumulator
//   MAC      | one feature product per cycle
//   OUT      | hold error until accepted
//   DONE     | one-cycle done pulse
module dp_error_engine
    import dp_pkg::*;
#(
    parameter int ADDR_WIDTH   = 3,
    parameter int MAX_FEATURES = 6,
    parameter int DATA_WIDTH   = 16 * (MAX_FEATURES + 1),
    parameter int DEPTH        = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_oe,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  err_valid,
    input  logic                  err_ready,
    output logic [FEAT_W-1:0]     err_data,
    output logic [ADDR_WIDTH-1:0] err_idx,
    output logic [DATA_WIDTH-1:0] row_out,
    output logic                  busy,
    output logic                  done
);
    localparam int KW = $clog2(MAX_FEATURES + 1);

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   w_q;
    logic [DATA_WIDTH-1:0]   row_q;
    logic [KW-1:0]           k_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [ADDR_WIDTH-1:0]   err_idx_q;
    logic [FEAT_W-1:0]       err_data_q;
    logic                    ram_oe_q;
    logic                    err_valid_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    mac_clr;
    logic                    mac_en;
    logic [FEAT_W-1:0]       mac_a;
    logic [FEAT_W-1:0]       mac_b;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] s_val;
    logic [FEAT_W-1:0]       bias;
    logic [FEAT_W-1:0]       y_val;
    logic [FEAT_W-1:0]       y_hat;
    logic [FEAT_W-1:0]       err_calc;
    logic                    last_k;

    assign mac_clr = (state_q == S_P_CAP);
    assign mac_en  = (state_q == S_MAC);
    assign mac_a   = slice(ROW_MAX_W'(w_q), int'(k_q));
    assign mac_b   = slice(ROW_MAX_W'(row_q), int'(k_q));
    assign bias    = slice(ROW_MAX_W'(w_q), MAX_FEATURES);
    assign y_val   = slice(ROW_MAX_W'(row_q), MAX_FEATURES);
    assign last_k  = (k_q == KW'(MAX_FEATURES - 1));

    fx_mac u_mac (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (mac_clr),
        .en_i      (mac_en),
        .a_i       (mac_a),
        .b_i       (mac_b),
        .acc_nxt_o (acc_nxt)
    );

    // Accumulator is Q16.16; aligning the bias and shifting back gives Q8.8 rounded toward -inf.
    assign s_val    = (acc_nxt + (sext(bias) <<< FRAC_BITS)) >>> FRAC_BITS;
    assign y_hat    = sat16(s_val);
    assign err_calc = sat16(sext(y_hat) - sext(y_val));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            row_q       <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            ram_addr_q  <= '0;
            err_idx_q   <= '0;
            err_data_q  <= '0;
            ram_oe_q    <= 1'b0;
            err_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_W_ADDR;
                    end
                end
                S_W_ADDR: begin
                    ram_addr_q <= '0;
                    ram_oe_q   <= 1'b1;
                    state_q    <= S_W_CAP;
                end
                S_W_CAP: begin
                    w_q     <= ram_data;
                    idx_q   <= ADDR_WIDTH'(1);
                    state_q <= S_P_ADDR;
                end
                S_P_ADDR: begin
                    ram_addr_q <= idx_q;
                    state_q    <= S_P_CAP;
                end
                S_P_CAP: begin
                    row_q   <= ram_data;
                    k_q     <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    k_q <= k_q + 1'b1;
                    if (last_k) begin
                        err_data_q  <= err_calc;
                        err_idx_q   <= idx_q;
                        err_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (err_ready) begin
                        err_valid_q <= 1'b0;
                        if (idx_q == ADDR_WIDTH'(DEPTH)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_P_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    done_q   <= 1'b0;
                    ram_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_oe    = ram_oe_q;
    assign ram_we    = 1'b0;
    assign err_valid = err_valid_q;
    assign err_data  = err_data_q;
    assign err_idx   = err_idx_q;
    assign row_out   = row_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
